// File: rtl/score_round_if.sv
// Board/display-side signal bundle of the score round controller.
// master drives start, score_btn and d; slave is the controller itself.
interface score_round_if #(
    parameter int TOTAL_W = 8
) ();
    logic               start;
    logic               score_btn;
    logic [3:0]         d;
    logic [3:0]         round_score;
    logic               score_valid;
    logic [TOTAL_W-1:0] p1_total;
    logic [TOTAL_W-1:0] p2_total;
    logic               active_player;
    logic [3:0]         round_idx;
    logic               busy;
    logic               done;
    logic [1:0]         winner;
    logic [2:0]         dbg_state;

    // score_valid is a one-cycle pulse; there is no backpressure on the outputs.
    modport master (
        output start, score_btn, d,
        input  round_score, score_valid, p1_total, p2_total, active_player,
               round_idx, busy, done, winner, dbg_state
    );

    modport slave (
        input  start, score_btn, d,
        output round_score, score_valid, p1_total, p2_total, active_player,
               round_idx, busy, done, winner, dbg_state
    );
endinterface

// File: rtl/score_round_controller.sv
// Two-player multi-round game sequencer: synchronises and debounces the score
// button, latches the switches on a press and accumulates weighted round scores.
module score_round_controller #(
    parameter int NUM_ROUNDS      = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TOTAL_W         = 8
) (
    input logic          clk,
    input logic          rst_n,
    score_round_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_PRESS, S_SCORE, S_WAIT_RELEASE, S_DONE
    } state_t;

    state_t             r_state;
    logic [1:0]         r_btn_sync;
    logic [3:0]         r_d_meta;
    logic [3:0]         r_d_sync;
    logic               r_btn_db;
    logic               r_btn_db_q;
    logic [CW-1:0]      r_db_cnt;
    logic [3:0]         r_d_lat;
    logic [3:0]         r_round_score;
    logic               r_score_valid;
    logic [TOTAL_W-1:0] r_p1_total;
    logic [TOTAL_W-1:0] r_p2_total;
    logic               r_active_player;
    logic [3:0]         r_round_idx;
    logic               r_busy;
    logic               r_done;
    logic [1:0]         r_winner;

    logic               w_press_evt;
    logic [3:0]         w_score;
    logic [TOTAL_W-1:0] w_active_total;
    logic [TOTAL_W:0]   w_sum;
    logic [TOTAL_W-1:0] w_new_total;
    logic [TOTAL_W-1:0] w_p1_next;
    logic [TOTAL_W-1:0] w_p2_next;
    logic [1:0]         w_winner;

    // btn_db only follows btn_sync after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_sync <= 2'b00;
            r_d_meta   <= 4'd0;
            r_d_sync   <= 4'd0;
            r_btn_db   <= 1'b0;
            r_btn_db_q <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_btn_sync <= {r_btn_sync[0], bus.score_btn};
            r_d_meta   <= bus.d;
            r_d_sync   <= r_d_meta;
            r_btn_db_q <= r_btn_db;
            if (r_btn_sync[1] == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == CNT_MAX) begin
                r_btn_db <= r_btn_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press_evt    = r_btn_db & ~r_btn_db_q;
    assign w_score        = {3'b000, r_d_lat[0]} + {2'b00, r_d_lat[1], 1'b0}
                          + {2'b00, r_d_lat[2], r_d_lat[2]} + {1'b0, r_d_lat[3], 2'b00};
    assign w_active_total = r_active_player ? r_p2_total : r_p1_total;
    assign w_sum          = {1'b0, w_active_total} + {{(TOTAL_W-3){1'b0}}, w_score};
    assign w_new_total    = w_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : w_sum[TOTAL_W-1:0];
    assign w_p1_next      = r_active_player ? r_p1_total : w_new_total;
    assign w_p2_next      = r_active_player ? w_new_total : r_p2_total;
    assign w_winner       = (w_p1_next > w_p2_next) ? 2'b01 :
                            (w_p2_next > w_p1_next) ? 2'b10 : 2'b11;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_d_lat         <= 4'd0;
            r_round_score   <= 4'd0;
            r_score_valid   <= 1'b0;
            r_p1_total      <= '0;
            r_p2_total      <= '0;
            r_active_player <= 1'b0;
            r_round_idx     <= 4'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_winner        <= 2'b00;
        end else begin
            r_score_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_p1_total      <= '0;
                        r_p2_total      <= '0;
                        r_round_idx     <= 4'd0;
                        r_active_player <= 1'b0;
                        r_winner        <= 2'b00;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_state         <= S_WAIT_PRESS;
                    end
                end
                S_WAIT_PRESS: begin
                    if (w_press_evt) begin
                        r_d_lat <= r_d_sync;
                        r_state <= S_SCORE;
                    end
                end
                S_SCORE: begin
                    r_round_score <= w_score;
                    r_p1_total    <= w_p1_next;
                    r_p2_total    <= w_p2_next;
                    r_score_valid <= 1'b1;
                    if (!r_active_player) begin
                        r_active_player <= 1'b1;
                        r_state         <= S_WAIT_RELEASE;
                    end else if (r_round_idx == LAST_ROUND) begin
                        r_winner <= w_winner;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_active_player <= 1'b0;
                        r_round_idx     <= r_round_idx + 4'd1;
                        r_state         <= S_WAIT_RELEASE;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (!r_btn_db) r_state <= S_WAIT_PRESS;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.round_score   = r_round_score;
    assign bus.score_valid   = r_score_valid;
    assign bus.p1_total      = r_p1_total;
    assign bus.p2_total      = r_p2_total;
    assign bus.active_player = r_active_player;
    assign bus.round_idx     = r_round_idx;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.winner        = r_winner;
    assign bus.dbg_state     = r_state;
endmodule
